// File: rtl/usb2_ep_in.sv
// usb2_ep_in - USB 2.0 IN endpoint with ping-pong transmit buffers.
//
// The application fills the free write bank and commits it with a length.
// The protocol layer reads the committed read bank during an IN transaction.
// A bank is released only after the host ACKs. An unacknowledged packet
// stays in place, with the same PID, so that it can be retried.
//
// Ports:
//   phy_clk, reset_n       clock, asynchronous active-low reset
//   app_wr_addr/data/en    byte write into the current write bank
//   app_commit(_len)       commit the write bank (length clamped to MAX_PKT)
//   app_ready              a free write bank exists
//   app_overflow           sticky: commit attempted with no free bank
//   xfer_in                level, IN transaction in progress
//   xfer_in_ok             pulse, host ACKed the data packet
//   toggle_clr             pulse, force next PID to DATA0
//   xfer_ready             committed packet available (else NAK)
//   xfer_pid               4'hC DATA0 / 4'h4 DATA1
//   buf_out_addr/q         read port into the read bank, 1-cycle latency
//   buf_out_len            length of the packet in the read bank
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for xfer_in rising edge with a full read bank
// ST_ACTIVE | packet being sent; collecting the host ACK until xfer_in falls
// ST_DONE   | one cycle: release the bank and flip the toggle if ACKed

module usb2_ep_in #(
   parameter int MAX_PKT = 512,
   parameter int ADDR_W  = 9
) (
   input  logic              phy_clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] app_wr_addr,
   input  logic [7:0]        app_wr_data,
   input  logic              app_wr_en,
   input  logic              app_commit,
   input  logic [9:0]        app_commit_len,
   output logic              app_ready,
   output logic              app_overflow,
   input  logic              xfer_in,
   input  logic              xfer_in_ok,
   input  logic              toggle_clr,
   output logic              xfer_ready,
   output logic [3:0]        xfer_pid,
   input  logic [ADDR_W-1:0] buf_out_addr,
   output logic [7:0]        buf_out_q,
   output logic [9:0]        buf_out_len
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_e;

   localparam logic [9:0] MAX_LEN = 10'(MAX_PKT);

   logic [7:0]       mem_q [0:(2**(ADDR_W+1))-1];
   logic [7:0]       rd_q;

   state_e           state_q, state_d;
   logic [1:0]       full_q, full_d;
   logic [1:0][9:0]  len_q, len_d;
   logic             wb_q, wb_d;
   logic             rb_q, rb_d;
   logic             tgl_q, tgl_d;
   logic             ack_q, ack_d;
   logic             ovf_q, ovf_d;
   logic             xfer_in_1_q, xfer_in_ok_1_q, toggle_clr_1_q;
   logic             in_rise, ok_rise, clr_rise;
   logic [9:0]       commit_len;

   // Storage has no reset; the bank pointers select the half of the RAM.
   always_ff @(posedge phy_clk) begin
      if (app_wr_en) begin
         mem_q[{wb_q, app_wr_addr}] <= app_wr_data;
      end
      rd_q <= mem_q[{rb_q, buf_out_addr}];
   end

   assign in_rise  = xfer_in    & ~xfer_in_1_q;
   assign ok_rise  = xfer_in_ok & ~xfer_in_ok_1_q;
   assign clr_rise = toggle_clr & ~toggle_clr_1_q;

   always_comb begin
      state_d    = state_q;
      full_d     = full_q;
      len_d      = len_q;
      wb_d       = wb_q;
      rb_d       = rb_q;
      tgl_d      = tgl_q;
      ack_d      = ack_q;
      ovf_d      = ovf_q;
      commit_len = (app_commit_len > MAX_LEN) ? MAX_LEN : app_commit_len;

      case (state_q)
         ST_IDLE: begin
            if (in_rise && full_q[rb_q]) begin
               state_d = ST_ACTIVE;
               ack_d   = 1'b0;
            end
         end
         ST_ACTIVE: begin
            // An ACK in the same cycle that xfer_in falls still counts.
            if (ok_rise) begin
               ack_d = 1'b1;
            end
            if (!xfer_in) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (ack_q) begin
               full_d[rb_q] = 1'b0;
               rb_d         = ~rb_q;
               tgl_d        = ~tgl_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A commit can only succeed on a non-full wb, which is never the bank
      // being released above, so both updates apply independently.
      if (app_commit) begin
         if (!full_q[wb_q]) begin
            full_d[wb_q] = 1'b1;
            len_d[wb_q]  = commit_len;
            wb_d         = ~wb_q;
         end else begin
            ovf_d = 1'b1;
         end
      end

      if (clr_rise) begin
         tgl_d = 1'b0;
      end
   end

   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         full_q         <= 2'b00;
         len_q          <= '0;
         wb_q           <= 1'b0;
         rb_q           <= 1'b0;
         tgl_q          <= 1'b0;
         ack_q          <= 1'b0;
         ovf_q          <= 1'b0;
         xfer_in_1_q    <= 1'b0;
         xfer_in_ok_1_q <= 1'b0;
         toggle_clr_1_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         full_q         <= full_d;
         len_q          <= len_d;
         wb_q           <= wb_d;
         rb_q           <= rb_d;
         tgl_q          <= tgl_d;
         ack_q          <= ack_d;
         ovf_q          <= ovf_d;
         xfer_in_1_q    <= xfer_in;
         xfer_in_ok_1_q <= xfer_in_ok;
         toggle_clr_1_q <= toggle_clr;
      end
   end

   assign app_ready    = ~full_q[wb_q];
   assign app_overflow = ovf_q;
   assign xfer_ready   = full_q[rb_q];
   assign xfer_pid     = tgl_q ? 4'h4 : 4'hC;
   assign buf_out_len  = len_q[rb_q];
   assign buf_out_q    = rd_q;

endmodule

// File: tb/tb_usb2_ep_in.sv
// Bench for usb2_ep_in. The reference model treats the endpoint as a
// two-deep FIFO of packets (length + data seed) plus a toggle bit and a
// sticky overflow flag.

module tb_usb2_ep_in;

   logic       phy_clk = 1'b0;
   logic       reset_n;
   logic [8:0] app_wr_addr;
   logic [7:0] app_wr_data;
   logic       app_wr_en;
   logic       app_commit;
   logic [9:0] app_commit_len;
   logic       app_ready;
   logic       app_overflow;
   logic       xfer_in;
   logic       xfer_in_ok;
   logic       toggle_clr;
   logic       xfer_ready;
   logic [3:0] xfer_pid;
   logic [8:0] buf_out_addr;
   logic [7:0] buf_out_q;
   logic [9:0] buf_out_len;

   usb2_ep_in dut (
      .phy_clk        (phy_clk),
      .reset_n        (reset_n),
      .app_wr_addr    (app_wr_addr),
      .app_wr_data    (app_wr_data),
      .app_wr_en      (app_wr_en),
      .app_commit     (app_commit),
      .app_commit_len (app_commit_len),
      .app_ready      (app_ready),
      .app_overflow   (app_overflow),
      .xfer_in        (xfer_in),
      .xfer_in_ok     (xfer_in_ok),
      .toggle_clr     (toggle_clr),
      .xfer_ready     (xfer_ready),
      .xfer_pid       (xfer_pid),
      .buf_out_addr   (buf_out_addr),
      .buf_out_q      (buf_out_q),
      .buf_out_len    (buf_out_len)
   );

   always #5 phy_clk = ~phy_clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int len;
      int seed;
   } pkt_t;

   pkt_t m_q[$];
   bit   m_tgl;
   bit   m_ovf;

   function automatic logic [7:0] pat(int seed, int a);
      if (seed == 0) return 8'(a + 1);
      return 8'((seed >> 3) ^ (a * 37) ^ seed);
   endfunction

   task automatic tick();
      @(posedge phy_clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(string tag);
      chk({tag, ".app_ready"},    32'(app_ready),    32'(m_q.size() < 2));
      chk({tag, ".xfer_ready"},   32'(xfer_ready),   32'(m_q.size() > 0));
      chk({tag, ".xfer_pid"},     32'(xfer_pid),     m_tgl ? 32'h4 : 32'hC);
      chk({tag, ".app_overflow"}, 32'(app_overflow), 32'(m_ovf));
      if (m_q.size() > 0) chk({tag, ".buf_out_len"}, 32'(buf_out_len), 32'(m_q[0].len));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      app_wr_addr = '0; app_wr_data = '0; app_wr_en = 1'b0;
      app_commit = 1'b0; app_commit_len = '0;
      xfer_in = 1'b0; xfer_in_ok = 1'b0; toggle_clr = 1'b0; buf_out_addr = '0;
      m_q.delete(); m_tgl = 1'b0; m_ovf = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Writes the first few bytes of a packet into the free write bank.
   task automatic write_bytes(int len, int seed);
      int ml = (len > 512) ? 512 : len;
      int n  = (ml < 16) ? ml : 16;
      for (int a = 0; a < n; a++) begin
         app_wr_addr = 9'(a);
         app_wr_data = pat(seed, a);
         app_wr_en   = 1'b1;
         tick();
      end
      app_wr_en = 1'b0;
   endtask

   task automatic model_commit(int len, int seed);
      pkt_t p;
      p.len  = (len > 512) ? 512 : len;
      p.seed = seed;
      if (m_q.size() < 2) m_q.push_back(p);
      else m_ovf = 1'b1;
   endtask

   task automatic fill_commit(int len, int seed);
      if (m_q.size() < 2) write_bytes(len, seed);
      app_commit     = 1'b1;
      app_commit_len = 10'(len);
      tick();
      app_commit = 1'b0;
      model_commit(len, seed);
   endtask

   task automatic read_check(string tag, pkt_t p);
      int n = (p.len < 16) ? p.len : 16;
      for (int a = 0; a < n; a++) begin
         buf_out_addr = 9'(a);
         tick();
         chk({tag, ".buf_out_q"}, 32'(buf_out_q), 32'(pat(p.seed, a)));
      end
   endtask

   // One IN transaction. Optionally: ACK (mid-transaction or together with
   // the xfer_in fall), toggle_clr and/or a commit in the ST_DONE cycle.
   task automatic do_in(string tag, bit ack, bit ack_at_fall, bit clr, bit cmt, int clen, int cseed);
      bit active = (m_q.size() > 0);
      if (cmt) write_bytes(clen, cseed);
      xfer_in = 1'b1;
      tick();
      if (active) read_check(tag, m_q[0]);
      else tick();
      if (ack && !ack_at_fall) begin
         xfer_in_ok = 1'b1; tick();
         xfer_in_ok = 1'b0; tick();
      end
      xfer_in = 1'b0;
      if (ack && ack_at_fall) xfer_in_ok = 1'b1;
      tick();
      xfer_in_ok = 1'b0;
      if (clr) toggle_clr = 1'b1;
      if (cmt) begin
         app_commit     = 1'b1;
         app_commit_len = 10'(clen);
      end
      tick();
      toggle_clr = 1'b0;
      app_commit = 1'b0;
      if (active && ack) begin
         void'(m_q.pop_front());
         m_tgl = ~m_tgl;
      end
      if (clr) m_tgl = 1'b0;
      if (cmt) model_commit(clen, cseed);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check_state("reset");
      chk("reset.buf_out_len", 32'(buf_out_len), 32'd0);

      fill_commit(8, 0);
      check_state("commit8");
      do_in("in_ack1", 1, 0, 0, 0, 0, 0);
      check_state("in_ack1");
      fill_commit(20, 5);
      check_state("commit20");
      do_in("in_ack2", 1, 0, 0, 0, 0, 0);
      check_state("in_ack2");

      fill_commit(30, 9);
      do_in("timeout", 0, 0, 0, 0, 0, 0);
      check_state("timeout");
      do_in("retry", 1, 0, 0, 0, 0, 0);
      check_state("retry");

      fill_commit(10, 3);
      do_in("pre_clr", 1, 0, 0, 0, 0, 0);
      check_state("pre_clr");
      fill_commit(11, 4);
      do_in("clr_done", 1, 0, 1, 0, 0, 0);
      check_state("clr_done");

      fill_commit(12, 6);
      do_in("ack_fall", 1, 1, 0, 0, 0, 0);
      check_state("ack_fall");

      fill_commit(40, 7);
      do_in("cmt_done", 1, 0, 0, 1, 50, 8);
      check_state("cmt_done");
      do_in("cmt_done2", 1, 0, 0, 0, 0, 0);
      check_state("cmt_done2");

      fill_commit(512, 11);
      check_state("ovf1");
      fill_commit(64, 12);
      check_state("ovf2");
      fill_commit(0, 13);
      check_state("ovf3");
      do_in("ovf_in1", 1, 0, 0, 0, 0, 0);
      check_state("ovf_in1");
      do_in("ovf_in2", 1, 0, 0, 0, 0, 0);
      check_state("ovf_in2");
      fill_commit(0, 14);
      check_state("zlp");
      do_in("zlp_in", 1, 0, 0, 0, 0, 0);
      check_state("zlp_in");
      fill_commit(700, 15);
      check_state("clamp");
      do_in("clamp_in", 1, 0, 0, 0, 0, 0);
      check_state("clamp_in");

      do_in("empty_in", 1, 0, 0, 0, 0, 0);
      check_state("empty_in");

      for (int i = 0; i < 40; i++) begin
         int op = $urandom_range(0, 3);
         if (op < 2 && m_q.size() < 2) begin
            fill_commit($urandom_range(0, 600), $urandom_range(1, 100000));
         end else begin
            bit cm = (m_q.size() < 2) && ($urandom_range(0, 2) == 0);
            do_in("rnd_in", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), cm,
                  $urandom_range(0, 600), $urandom_range(1, 100000));
         end
         check_state("rnd");
      end

      do_reset();
      fill_commit(5, 21);
      xfer_in = 1'b1;
      tick(); tick();
      reset_n = 1'b0;
      #1;
      chk("async_rst.app_ready",    32'(app_ready),    32'd1);
      chk("async_rst.app_overflow", 32'(app_overflow), 32'd0);
      chk("async_rst.xfer_ready",   32'(xfer_ready),   32'd0);
      chk("async_rst.xfer_pid",     32'(xfer_pid),     32'hC);
      chk("async_rst.buf_out_len",  32'(buf_out_len),  32'd0);
      xfer_in = 1'b0;
      do_reset();
      fill_commit(6, 22);
      do_in("post_rst", 1, 0, 0, 0, 0, 0);
      check_state("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usb2_ep_in.md
Name: usb2_ep_in

Overview:
USB 2.0 IN endpoint: device-to-host data path, the transmit counterpart of the OUT/SETUP receive endpoint. Application logic fills one of two ping-pong packet buffers and commits it with a length. The protocol layer reads the committed packet out on an IN token. The block tracks DATA0/DATA1 toggle and frees a buffer only on host ACK, so unacknowledged packets are retried.

Parameters:
MAX_PKT, 512, max payload bytes per packet (1..512); commit lengths above this are clamped
ADDR_W, 9, byte address width of each bank

Ports:
phy_clk  in  1  endpoint clock (60 MHz ULPI domain)
reset_n  in  1  asynchronous active-low reset
app_wr_addr  in  9  byte address within current write bank
app_wr_data  in  8  byte to write
app_wr_en  in  1  write strobe
app_commit  in  1  1-cycle pulse: current write bank holds a packet
app_commit_len  in  10  packet length in bytes, 0..512 (0 = ZLP)
app_ready  out  1  a free write bank exists
app_overflow  out  1  sticky: commit attempted with no free bank; cleared only by reset
xfer_in  in  1  level, high for the duration of an IN transaction to this endpoint
xfer_in_ok  in  1  pulse: host ACKed the data packet
toggle_clr  in  1  pulse: force next PID to DATA0 (SET_CONFIGURATION / CLEAR_FEATURE)
xfer_ready  out  1  committed packet available; low means the protocol layer NAKs
xfer_pid  out  4  PID to send: 4'hC DATA0 or 4'h4 DATA1
buf_out_addr  in  9  read address into current read bank
buf_out_q  out  8  read data
buf_out_len  out  10  length of the packet in the current read bank

Behaviour:
- Storage: two MAX_PKT-byte banks in one dual-port RAM of 2*512 x 8. Write address is {wb, app_wr_addr}; read address is {rb, buf_out_addr}. buf_out_q is registered, valid 1 cycle after buf_out_addr.
- Per-bank state: full[1:0] and len0, len1. Pointers: wb = write bank, rb = read bank. Toggle bit tgl.
- Reset (async): full=00, wb=rb=0, tgl=0, len0=len1=0, state=ST_IDLE. Outputs at reset: app_ready=1, app_overflow=0, xfer_ready=0, xfer_pid=4'hC, buf_out_len=0.
- Outputs: app_ready = ~full[wb]. xfer_ready = full[rb]. buf_out_len = len[rb]. xfer_pid = tgl ? 4'h4 : 4'hC. All are registered or driven directly from registers.
- Commit: app_commit with full[wb]=0 writes len[wb] = min(app_commit_len, MAX_PKT), sets full[wb]=1 and toggles wb, all on the next edge. Commit with full[wb]=1 is ignored and sets app_overflow. Writes to a full bank still go to RAM; preventing them is the application's responsibility.
- xfer_in, xfer_in_ok and toggle_clr are each registered once, giving *_1. Edge = sig & ~sig_1.
- FSM:
  - ST_IDLE: on xfer_in rising edge:
    - if full[rb], go to ST_ACTIVE and clear ack_seen;
    - else stay in ST_IDLE (NAK case, no state change).
  - ST_ACTIVE: a rising edge of xfer_in_ok sets ack_seen. When xfer_in=0, go to ST_DONE.
  - ST_DONE (1 cycle):
    - if ack_seen: full[rb]=0, rb toggles, tgl flips;
    - else: the buffer is retained, with the same PID and the same rb (host retries).
    - Go to ST_IDLE.
- rb and len[rb] stay stable from ST_ACTIVE entry until ST_DONE completes. A commit during ST_ACTIVE only affects wb and is legal.
- Simultaneous commit and ST_DONE free in the same cycle: both apply. app_ready reflects the result on the next cycle.
- xfer_in_ok arriving in the same cycle xfer_in falls still counts as an ACK.
- toggle_clr forces tgl=0 and takes priority over an ACK flip in the same cycle. It does not alter buffers.
- ZLP: len=0 is committed and sent like any packet. xfer_ready=1 and buf_out_len=0.
- xfer_in rising while already in ST_ACTIVE or ST_DONE is ignored.

Test Plan:
- Reset, write 8 bytes 0x01..0x08 and commit len 8 -> next cycle xfer_ready=1, buf_out_len=8, xfer_pid=4'hC. Reading addr 0..7 returns 0x01..0x08 with 1-cycle latency.
- IN with xfer_in_ok -> after xfer_in falls, xfer_ready=0, xfer_pid=4'h4, app_ready=1. A second committed packet goes out with DATA1, and after its ACK xfer_pid returns to 4'hC.
- IN without xfer_in_ok (timeout) -> xfer_ready stays 1, same data, xfer_pid unchanged. A subsequent ACKed retry frees the buffer.
- Commit 3 packets (len 512, 64, 0) without any IN -> app_ready=0 after the second commit, app_overflow=1 after the third. Commit len 700 -> buf_out_len=512.
- Two full banks, ACK the first while committing nothing -> rb switches, buf_out_len=64. IN on an empty endpoint -> FSM stays in ST_IDLE, xfer_ready=0.
- toggle_clr pulsed in the same cycle as ST_DONE with ACK -> xfer_pid=4'hC. Assert reset_n=0 mid-ST_ACTIVE -> all outputs return to reset values immediately.
